// File: rtl/mem_responder.sv
// mem_responder: strobe-driven memory responder with a side-band loader port.
// Define MEM_CLEAR_EN to zero the whole array after every reset (busy during the walk).
module mem_responder #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic              data_e,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              bus_err,
    input  logic              ld_valid,
    input  logic [AWIDTH-1:0] ld_addr,
    input  logic [DWIDTH-1:0] ld_data,
    output logic              ld_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, READ, WARM, COMMIT} state_t;
    state_t state_q;
    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [AWIDTH-1:0] waddr_q, clr_addr, wa;
    logic [DWIDTH-1:0] wdata_q, wd, rd_word, rdata_q;
    logic rvalid_q, bus_err_q, we, clearing;
`ifdef MEM_CLEAR_EN
    logic busy_q;
    logic [AWIDTH-1:0] clr_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b1;
            clr_q  <= '0;
        end else if (busy_q) begin
            clr_q  <= clr_q + 1'b1;
            busy_q <= clr_q != '1;
        end
    end
    assign clearing = busy_q;
    assign clr_addr = clr_q;
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif
    assign busy     = clearing;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign bus_err  = bus_err_q;
    assign ld_ready = rst_n && state_q == IDLE && !rd && !wr && !clearing;
    assign we       = clearing || (rst_n && (state_q == COMMIT || (ld_valid && ld_ready)));
    assign wa       = clearing ? clr_addr : state_q == COMMIT ? waddr_q : ld_addr;
    assign wd       = clearing ? '0 : state_q == COMMIT ? wdata_q : ld_data;
    // a read landing on the commit cycle sees the word being written
    assign rd_word  = (state_q == COMMIT && addr == waddr_q) ? wdata_q : mem[addr];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            bus_err_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else if (clearing) begin
            rvalid_q <= 1'b0;
            if (rd || wr) bus_err_q <= 1'b1;
        end else if (state_q == WARM) begin
            rvalid_q <= 1'b0;
            if (rd || (wr && !data_e)) begin
                bus_err_q <= 1'b1;
                state_q   <= IDLE;
            end else if (wr) begin
                waddr_q <= addr;
                wdata_q <= wdata;
            end else begin
                state_q <= COMMIT;
            end
        end else begin
            rvalid_q <= rd && !wr;
            if (rd && wr) begin
                bus_err_q <= 1'b1;
                state_q   <= IDLE;
            end else if (rd) begin
                rdata_q <= rd_word;
                state_q <= READ;
            end else if (wr && !data_e) begin
                bus_err_q <= 1'b1;
                state_q   <= IDLE;
            end else if (wr) begin
                waddr_q <= addr;
                wdata_q <= wdata;
                state_q <= WARM;
            end else begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus randomized transactions checked against a word-array model.
module tb_mem_responder;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0] addr = '0, ld_addr = '0;
    logic rd = 1'b0, wr = 1'b0, data_e = 1'b0, ld_valid = 1'b0;
    logic [DW-1:0] wdata = '0, ld_data = '0;
    logic [DW-1:0] rdata;
    logic rvalid, bus_err, ld_ready, busy;
    logic [DW-1:0] ref_mem [N];
    bit known [N];
    logic [AW-1:0] wa_m;
    logic [DW-1:0] wd_m, last_rd;
    bit last_known;
    int total = 0, passed = 0, failed = 0;

    mem_responder #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .data_e(data_e),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .bus_err(bus_err),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rd = 1'b0; wr = 1'b0; data_e = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic do_reset();
        int cnt;
        idle_in();
        rst_n = 1'b0;
        tick();
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_ld_ready", ld_ready, 0);
        rst_n = 1'b1;
        last_rd = '0;
        last_known = 1'b1;
`ifdef MEM_CLEAR_EN
        cnt = 0;
        ld_valid = 1'b1; ld_addr = '0; ld_data = 8'hEE;
        while (busy === 1'b1 && cnt < 100) begin
            if (ld_ready !== 1'b0) chk("walk_ld_ready", ld_ready, 0);
            tick();
            cnt++;
        end
        chk("walk_busy_cycles", cnt, N);
        chk("walk_ld_ready_after", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            ref_mem[i] = '0;
            known[i] = 1'b1;
        end
        ref_mem[0] = 8'hEE;
`else
        chk("busy_tied", busy, 0);
        tick();
`endif
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd = 1'b0; wr = 1'b0; ld_valid = 1'b1; ld_addr = a; ld_data = d;
        #1;
        chk("ld_ready", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        ref_mem[a] = d;
        known[a] = 1'b1;
    endtask

    task automatic wr_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd = 1'b0; wr = 1'b1; data_e = 1'b1; addr = a; wdata = d;
        tick();
        wa_m = a;
        wd_m = d;
    endtask

    task automatic wr_end();
        wr = 1'b0; data_e = 1'b0;
        tick();
        ref_mem[wa_m] = wd_m;
        known[wa_m] = 1'b1;
    endtask

    task automatic rd_cycle(input logic [AW-1:0] a);
        rd = 1'b1; wr = 1'b0; addr = a;
        tick();
        chk("rvalid", rvalid, 1);
        last_known = known[a];
        last_rd = ref_mem[a];
        if (known[a]) chk($sformatf("rdata@%0d", a), rdata, ref_mem[a]);
    endtask

    task automatic rd_end();
        rd = 1'b0;
        tick();
        chk("rvalid_drop", rvalid, 0);
        if (last_known) chk("rdata_hold", rdata, last_rd);
    endtask

    initial begin
        int n;
        logic [AW-1:0] a;
        for (int i = 0; i < N; i++) known[i] = 1'b0;
        do_reset();
        // loader then back-to-back reads
        load(5'd3, 8'hA5);
        load(5'd4, 8'h3C);
        rd_cycle(5'd3);
        rd_cycle(5'd4);
        rd_end();
        // last pair of a multi-cycle write wins
        wr_cycle(5'd7, 8'h12);
        wr_cycle(5'd7, 8'h34);
        wr_end();
        tick();
        rd_cycle(5'd7);
        rd_end();
        // write-first forwarding on the commit cycle
        wr_cycle(5'd12, 8'h6B);
        wr_end();
        rd_cycle(5'd12);
        rd_end();
        // rd and wr together
        load(5'd5, 8'h55);
        rd = 1'b1; wr = 1'b1; data_e = 1'b1; addr = 5'd5; wdata = 8'hF0;
        tick();
        chk("rdwr_bus_err", bus_err, 1);
        chk("rdwr_rvalid", rvalid, 0);
        if (last_known) chk("rdwr_rdata_hold", rdata, last_rd);
        idle_in();
        tick();
        chk("bus_err_sticky", bus_err, 1);
        rd_cycle(5'd5);
        rd_end();
        chk("bus_err_sticky2", bus_err, 1);
        do_reset();
        // wr without data_e
        load(5'd9, 8'h99);
        wr = 1'b1; data_e = 1'b0; addr = 5'd9; wdata = 8'h00;
        tick();
        chk("nodata_bus_err", bus_err, 1);
        idle_in();
        tick();
        rd_cycle(5'd9);
        rd_end();
        // rd during an armed write drops it
        load(5'd10, 8'h77);
        wr_cycle(5'd10, 8'hC3);
        rd = 1'b1; wr = 1'b0; data_e = 1'b0;
        tick();
        idle_in();
        tick();
        tick();
        rd_cycle(5'd10);
        rd_end();
        do_reset();
        // reset while a write is armed discards it
        load(5'd2, 8'h11);
        wr_cycle(5'd2, 8'hFF);
        do_reset();
        rd_cycle(5'd2);
        rd_end();
        chk("bus_err_clear", bus_err, 0);
        // randomized traffic
        for (int i = 0; i < N; i++) if (!known[i]) load(AW'(i), DW'($urandom));
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: load(AW'($urandom), DW'($urandom));
                1: begin
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++) wr_cycle(AW'($urandom), DW'($urandom));
                    wr_end();
                    if ($urandom_range(0, 1) == 1) begin
                        rd_cycle(wa_m);
                        rd_end();
                    end else begin
                        idle_in();
                        tick();
                    end
                end
                default: begin
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) begin
                        a = AW'($urandom);
                        rd_cycle(a);
                    end
                    rd_end();
                end
            endcase
        end
        chk("final_bus_err", bus_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
